// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter for the core data-memory port.
// Granted requester IDs are queued in order so each response returns to its issuer.
module data_bus_arbiter #(
   parameter int unsigned ADDR_W          = 32,
   parameter int unsigned DATA_W          = 32,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic                               m0_req_i,
   input  logic [ADDR_W-1:0]                  m0_addr_i,
   input  logic                               m0_we_i,
   input  logic [DATA_W/8-1:0]                m0_be_i,
   input  logic [DATA_W-1:0]                  m0_wdata_i,
   output logic                               m0_gnt_o,
   output logic                               m0_rvalid_o,
   output logic [DATA_W-1:0]                  m0_rdata_o,
   output logic                               m0_err_o,
   input  logic                               m1_req_i,
   input  logic [ADDR_W-1:0]                  m1_addr_i,
   input  logic                               m1_we_i,
   input  logic [DATA_W/8-1:0]                m1_be_i,
   input  logic [DATA_W-1:0]                  m1_wdata_i,
   output logic                               m1_gnt_o,
   output logic                               m1_rvalid_o,
   output logic [DATA_W-1:0]                  m1_rdata_o,
   output logic                               m1_err_o,
   output logic                               mem_req_o,
   output logic [ADDR_W-1:0]                  mem_addr_o,
   output logic                               mem_we_o,
   output logic [DATA_W/8-1:0]                mem_be_o,
   output logic [DATA_W-1:0]                  mem_wdata_o,
   input  logic                               mem_gnt_i,
   input  logic                               mem_rvalid_i,
   input  logic [DATA_W-1:0]                  mem_rdata_i,
   input  logic                               mem_err_i,
   output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
   output logic                               unexpected_rvalid_o,
   output logic                               state_o
);

   // Handshake: a request is transferred in the cycle mem_req_o & mem_gnt_i;
   // once forwarded, the selected request stays on mem_* until that cycle.
   localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

   state_e            state_q, state_d;
   logic              sel, sel_q, rr_q, fwd, grant, push, pop, full, empty, head_id;
   logic              id_mem_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign empty   = (count_q == '0);
   assign head_id = id_mem_q[rd_ptr_q];

   always_comb begin
      state_d = state_q;
      sel     = 1'b0;
      fwd     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!full && (m0_req_i || m1_req_i)) begin
               fwd = 1'b1;
               sel = (m0_req_i && m1_req_i) ? rr_q : m1_req_i;
               if (!mem_gnt_i) state_d = HOLD;
            end
         end
         HOLD: begin
            // Only the latched requester is considered; a dropped req abandons it.
            sel     = sel_q;
            fwd     = sel_q ? m1_req_i : m0_req_i;
            state_d = (fwd && !mem_gnt_i) ? HOLD : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (fwd) begin
         if (sel) begin
            mem_addr_o  = m1_addr_i;
            mem_we_o    = m1_we_i;
            mem_be_o    = m1_be_i;
            mem_wdata_o = m1_wdata_i;
         end else begin
            mem_addr_o  = m0_addr_i;
            mem_we_o    = m0_we_i;
            mem_be_o    = m0_be_i;
            mem_wdata_o = m0_wdata_i;
         end
      end
   end

   assign mem_req_o = fwd;
   assign grant     = fwd & mem_gnt_i;
   assign m0_gnt_o  = grant & ~sel;
   assign m1_gnt_o  = grant & sel;
   assign push      = grant;
   assign pop       = mem_rvalid_i & ~empty;

   assign m0_rvalid_o = pop & ~head_id;
   assign m1_rvalid_o = pop & head_id;
   assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : '0;
   assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : '0;
   assign m0_err_o    = m0_rvalid_o & mem_err_i;
   assign m1_err_o    = m1_rvalid_o & mem_err_i;

   assign outstanding_o = count_q;
   assign state_o       = (state_q == HOLD);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q             <= IDLE;
         sel_q               <= 1'b0;
         rr_q                <= 1'b0;
         wr_ptr_q            <= '0;
         rd_ptr_q            <= '0;
         count_q             <= '0;
         unexpected_rvalid_o <= 1'b0;
         for (int i = 0; i < int'(MAX_OUTSTANDING); i++) id_mem_q[i] <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && fwd && !mem_gnt_i) sel_q <= sel;
         if (grant) rr_q <= ~sel;
         if (push) begin
            id_mem_q[wr_ptr_q] <= sel;
            wr_ptr_q           <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
         if (mem_rvalid_i && empty) unexpected_rvalid_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: a queue-based reference model checked
// every falling edge, plus literal expectations at hand-picked cycles.
module tb_data_bus_arbiter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
   logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
   logic [3:0]  m0_be_i, m1_be_i;
   logic        m0_gnt_o, m0_rvalid_o, m0_err_o, m1_gnt_o, m1_rvalid_o, m1_err_o;
   logic [31:0] m0_rdata_o, m1_rdata_o;
   logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;
   logic [1:0]  outstanding_o;
   logic        unexpected_rvalid_o, state_o;

   int n_cmp = 0;
   int n_err = 0;

   data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(2)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
      .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o),
      .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
      .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
      .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o),
      .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .outstanding_o(outstanding_o), .unexpected_rvalid_o(unexpected_rvalid_o),
      .state_o(state_o)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish (n_cmp=%0d)", n_cmp);
      $fatal(1);
   end

   // ---------------- check helpers ----------------
   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // exp_q holds requester IDs of granted, unanswered transactions, oldest first.
   logic        exp_q[$];
   logic        m_rr, m_hold, m_hold_id, m_unexp;
   logic        e_req, e_cand, e_g0, e_g1, e_rv0, e_rv1;
   logic [31:0] e_addr, e_wdata;
   logic        e_we;
   logic [3:0]  e_be;

   always @(negedge clk_i) begin
      if (!rst_ni) begin
         exp_q.delete();
         m_rr = 1'b0; m_hold = 1'b0; m_hold_id = 1'b0; m_unexp = 1'b0;
         chk1("rst_mem_req", mem_req_o, 1'b0);
         chk32("rst_mem_addr", mem_addr_o, 32'h0);
         chk1("rst_m0_gnt", m0_gnt_o, 1'b0);
         chk1("rst_m1_gnt", m1_gnt_o, 1'b0);
         chk1("rst_m0_rvalid", m0_rvalid_o, 1'b0);
         chk1("rst_m1_rvalid", m1_rvalid_o, 1'b0);
         chk32("rst_outstanding", 32'(outstanding_o), 32'd0);
         chk1("rst_unexpected", unexpected_rvalid_o, 1'b0);
         chk1("rst_state", state_o, 1'b0);
      end else begin
         e_req  = 1'b0;
         e_cand = 1'b0;
         if (m_hold) begin
            e_cand = m_hold_id;
            e_req  = m_hold_id ? m1_req_i : m0_req_i;
         end else if (exp_q.size() < 2 && (m0_req_i || m1_req_i)) begin
            e_req  = 1'b1;
            e_cand = (m0_req_i && m1_req_i) ? m_rr : m1_req_i;
         end
         e_addr  = !e_req ? 32'h0 : (e_cand ? m1_addr_i  : m0_addr_i);
         e_wdata = !e_req ? 32'h0 : (e_cand ? m1_wdata_i : m0_wdata_i);
         e_we    = e_req && (e_cand ? m1_we_i : m0_we_i);
         e_be    = !e_req ? 4'h0 : (e_cand ? m1_be_i : m0_be_i);
         e_g0    = e_req && mem_gnt_i && !e_cand;
         e_g1    = e_req && mem_gnt_i && e_cand;
         e_rv0   = mem_rvalid_i && exp_q.size() > 0 && exp_q[0] == 1'b0;
         e_rv1   = mem_rvalid_i && exp_q.size() > 0 && exp_q[0] == 1'b1;

         chk1("mem_req", mem_req_o, e_req);
         chk32("mem_addr", mem_addr_o, e_addr);
         chk32("mem_wdata", mem_wdata_o, e_wdata);
         chk1("mem_we", mem_we_o, e_we);
         chk32("mem_be", 32'(mem_be_o), 32'(e_be));
         chk1("m0_gnt", m0_gnt_o, e_g0);
         chk1("m1_gnt", m1_gnt_o, e_g1);
         chk1("m0_rvalid", m0_rvalid_o, e_rv0);
         chk1("m1_rvalid", m1_rvalid_o, e_rv1);
         chk32("m0_rdata", m0_rdata_o, e_rv0 ? mem_rdata_i : 32'h0);
         chk32("m1_rdata", m1_rdata_o, e_rv1 ? mem_rdata_i : 32'h0);
         chk1("m0_err", m0_err_o, e_rv0 && mem_err_i);
         chk1("m1_err", m1_err_o, e_rv1 && mem_err_i);
         chk32("outstanding", 32'(outstanding_o), 32'(exp_q.size()));
         chk1("unexpected", unexpected_rvalid_o, m_unexp);
         chk1("state_hold", state_o, m_hold);

         if (mem_rvalid_i) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else m_unexp = 1'b1;
         end
         if (e_req && mem_gnt_i) begin
            exp_q.push_back(e_cand);
            m_rr   = ~e_cand;
            m_hold = 1'b0;
         end else if (e_req) begin
            m_hold    = 1'b1;
            m_hold_id = e_cand;
         end else begin
            m_hold = 1'b0;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic r0, input logic [31:0] a0, input logic we0,
                        input logic r1, input logic [31:0] a1, input logic we1,
                        input logic gnt, input logic rv, input logic [31:0] rd,
                        input logic err);
      m0_req_i = r0; m0_addr_i = a0; m0_we_i = we0; m0_be_i = 4'hF;
      m0_wdata_i = a0 ^ 32'hA5A5_0000;
      m1_req_i = r1; m1_addr_i = a1; m1_we_i = we1; m1_be_i = 4'h3;
      m1_wdata_i = a1 ^ 32'h5A5A_0000;
      mem_gnt_i = gnt; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = err;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      idle();
      step();
      step();
      rst_ni = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_ni = 1'b0;
      idle();
      step();
      step();
      rst_ni = 1'b1;
      chk32("lit_reset_outstanding", 32'(outstanding_o), 32'd0);

      // single m0 read, response two cycles after grant
      drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("lit_t1_m0_gnt", m0_gnt_o, 1'b1);
      chk32("lit_t1_addr", mem_addr_o, 32'h100);
      step();
      idle();
      chk32("lit_t1_out1", 32'(outstanding_o), 32'd1);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      chk1("lit_t1_m0_rv", m0_rvalid_o, 1'b1);
      chk32("lit_t1_rdata", m0_rdata_o, 32'hDEADBEEF);
      chk1("lit_t1_m1_rv", m1_rvalid_o, 1'b0);
      step();
      idle();
      chk32("lit_t1_out0", 32'(outstanding_o), 32'd0);
      step();

      // both requesting with gnt always high: alternating grants from m0
      do_reset();
      for (int i = 0; i < 7; i++) begin
         drive(i < 6, 32'(32'h1000 + i * 4), 1'b0, i < 6, 32'(32'h2000 + i * 4), 1'b1,
               i < 6, i > 0, 32'(32'h7000 + i), 1'b0);
         if (i < 6) begin
            chk1("lit_t2_m0_gnt", m0_gnt_o, (i % 2) == 0);
            chk1("lit_t2_m1_gnt", m1_gnt_o, (i % 2) == 1);
         end
         if (i > 0) begin
            chk1("lit_t2_m0_rv", m0_rvalid_o, ((i - 1) % 2) == 0);
            chk1("lit_t2_m1_rv", m1_rvalid_o, ((i - 1) % 2) == 1);
         end
         step();
      end

      // m1 held three cycles without grant while m0 joins
      drive(1'b0, 32'h300, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk32("lit_t3_addr_c0", mem_addr_o, 32'h200);
      step();
      for (int i = 1; i < 3; i++) begin
         drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
         chk32("lit_t3_addr_hold", mem_addr_o, 32'h200);
         chk1("lit_t3_state", state_o, 1'b1);
         step();
      end
      drive(1'b1, 32'h300, 1'b0, 1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("lit_t3_m1_gnt", m1_gnt_o, 1'b1);
      chk1("lit_t3_m0_gnt0", m0_gnt_o, 1'b0);
      step();
      drive(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("lit_t3_m0_gnt", m0_gnt_o, 1'b1);
      chk32("lit_t3_addr_m0", mem_addr_o, 32'h300);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
      chk1("lit_t3_rv_m1", m1_rvalid_o, 1'b1);
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
      chk1("lit_t3_rv_m0", m0_rvalid_o, 1'b1);
      step();

      // FIFO full: third m0 request blocked until the cycle after a pop
      drive(1'b1, 32'hA0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      drive(1'b1, 32'hA4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      drive(1'b1, 32'hA8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("lit_t4_full_req", mem_req_o, 1'b0);
      chk32("lit_t4_out2", 32'(outstanding_o), 32'd2);
      step();
      drive(1'b1, 32'hA8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h33, 1'b0);
      chk1("lit_t4_popcyc_gnt", m0_gnt_o, 1'b0);
      chk1("lit_t4_popcyc_rv", m0_rvalid_o, 1'b1);
      step();
      drive(1'b1, 32'hA8, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("lit_t4_third_gnt", m0_gnt_o, 1'b1);
      chk32("lit_t4_third_addr", mem_addr_o, 32'hA8);
      step();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(32'h40 + i), 1'b0);
         step();
      end

      // m1 write with error response
      drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      chk1("lit_t5_we", mem_we_o, 1'b1);
      chk32("lit_t5_wdata", mem_wdata_o, 32'h5A5A_0400);
      step();
      idle();
      step();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
      chk1("lit_t5_m1_rv", m1_rvalid_o, 1'b1);
      chk1("lit_t5_m1_err", m1_err_o, 1'b1);
      chk1("lit_t5_m0_rv", m0_rvalid_o, 1'b0);
      step();

      // unexpected rvalid, then reset in the middle of a HOLD
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
      chk1("lit_t6_no_rv0", m0_rvalid_o, 1'b0);
      chk1("lit_t6_no_rv1", m1_rvalid_o, 1'b0);
      step();
      idle();
      chk1("lit_t6_unexp", unexpected_rvalid_o, 1'b1);
      step();
      drive(1'b1, 32'hB0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step();
      drive(1'b1, 32'hB4, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      step();
      chk1("lit_t6_in_hold", state_o, 1'b1);
      chk1("lit_t6_unexp_sticky", unexpected_rvalid_o, 1'b1);
      rst_ni = 1'b0;
      idle();
      chk1("lit_t6_rst_state", state_o, 1'b0);
      chk32("lit_t6_rst_out", 32'(outstanding_o), 32'd0);
      chk1("lit_t6_rst_unexp", unexpected_rvalid_o, 1'b0);
      step();
      step();
      rst_ni = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h66, 1'b0);
      chk1("lit_t6_stale_rv", m0_rvalid_o, 1'b0);
      step();
      idle();
      chk1("lit_t6_stale_unexp", unexpected_rvalid_o, 1'b1);
      step();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
